// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad slave.
// sp_parity is only referenced when SCRATCHPAD_PARITY_EN is defined.
package scratchpad_pkg;

  typedef enum logic {
    SP_CLEAR = 1'b0,
    SP_READY = 1'b1
  } sp_state_e;

  localparam int SP_CNT_WIDTH = 32;
  localparam int SP_PAR_MAX_W = 64;

  // Zero-extension does not change parity, so narrower words can be widened to the fixed argument width.
  function automatic logic sp_parity(input logic [SP_PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with one write port and a registered read port.
// The array has no reset; only the read register is reset.
module sp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scratchpad_slave.sv
// Word-organised scratchpad slave with hardware clear sequence and saturating access counters.
// Define SCRATCHPAD_PARITY_EN to store an even-parity bit per word and flag read mismatches.
//
// state    | meaning
// SP_CLEAR | zeroing mem[clear_ptr] each cycle, requests and clear pulses ignored
// SP_READY | servicing one read or write per cycle
module scratchpad_slave
  import scratchpad_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  input  logic                    i_clear_req,
  output logic                    o_ready,
  output logic [SP_CNT_WIDTH-1:0] o_rd_count,
  output logic [SP_CNT_WIDTH-1:0] o_wr_count,
  output logic                    o_parity_err
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef SCRATCHPAD_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  sp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
  logic              ready_q, ready_d;
  logic [SP_CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic                  ram_we, ram_re, clear_entry;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [RAM_W-1:0]      ram_wdata, ram_rdata;

  logic [IDX_W-1:0] idx;
  logic             is_wr;
  logic             unused_addr_bits;

  assign idx   = i_addr[IDX_W+1:2];
  assign is_wr = i_addr[ADDR_WIDTH-1];
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[ADDR_WIDTH-2:IDX_W+2]};

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = idx;
    wr_data     = i_wdata;
    clear_entry = 1'b0;
    case (state_q)
      SP_CLEAR: begin
        ram_we      = 1'b1;
        ram_addr    = clear_ptr_q;
        wr_data     = '0;
        clear_ptr_d = clear_ptr_q + IDX_W'(1);
        if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = SP_READY;
          ready_d = 1'b1;
        end
      end
      SP_READY: begin
        if (i_req) begin
          if (is_wr) begin
            ram_we = 1'b1;
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + SP_CNT_WIDTH'(1);
          end else begin
            ram_re = 1'b1;
            if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + SP_CNT_WIDTH'(1);
          end
        end
        // The access above still happens on the edge that starts the clear.
        if (i_clear_req) begin
          state_d     = SP_CLEAR;
          ready_d     = 1'b0;
          clear_ptr_d = '0;
          clear_entry = 1'b1;
        end
      end
      default: state_d = SP_CLEAR;
    endcase
  end

`ifdef SCRATCHPAD_PARITY_EN
  logic rd_vld_q, rd_vld_d, perr_q, perr_d, rd_mismatch;

  assign ram_wdata   = {sp_parity(SP_PAR_MAX_W'(wr_data)), wr_data};
  assign rd_mismatch = rd_vld_q && (state_q == SP_READY) &&
    (ram_rdata[DATA_WIDTH] != sp_parity(SP_PAR_MAX_W'(ram_rdata[DATA_WIDTH-1:0])));

  always_comb begin
    rd_vld_d = ram_re;
    perr_d   = perr_q | rd_mismatch;
    if (clear_entry) perr_d = 1'b0;
  end

  // The live mismatch term lets the flag rise on the same edge that loads o_rdata.
  assign o_parity_err = perr_q | rd_mismatch;
`else
  assign ram_wdata    = wr_data;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SP_CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
`ifdef SCRATCHPAD_PARITY_EN
      rd_vld_q    <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
`ifdef SCRATCHPAD_PARITY_EN
      rd_vld_q    <= rd_vld_d;
      perr_q      <= perr_d;
`endif
    end
  end

  sp_ram #(
    .WIDTH(RAM_W),
    .DEPTH(DEPTH),
    .AW   (IDX_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign o_rdata    = ram_rdata[DATA_WIDTH-1:0];
  assign o_ready    = ready_q;
  assign o_rd_count = rd_cnt_q;
  assign o_wr_count = wr_cnt_q;

endmodule

// File: doc/scratchpad_slave.md
# scratchpad_slave

Single-port, word-organised scratchpad memory that sits directly downstream of the shared interconnect as one of its slave endpoints. It consumes one slave channel (req/addr/wdata) and returns read data on that channel's rdata. After reset it runs a hardware clear sequence before accepting traffic. It also keeps saturating read/write access counters for bring-up and debug.

## Interface
Parameters:
- DEPTH, 1024: number of DATA_WIDTH words; power of two, 2..4096.
- ADDR_WIDTH, 32: byte address width, equal to the interconnect's.
- DATA_WIDTH, 32: word width, equal to the interconnect's.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  1  access request from the interconnect slave channel.
- i_addr  input  ADDR_WIDTH  byte address; bit ADDR_WIDTH-1 = 1 means write, 0 means read.
- i_wdata  input  DATA_WIDTH  write data, sampled when i_req is high and the request is a write.
- o_rdata  output  DATA_WIDTH  registered read data.
- i_clear_req  input  1  single-cycle pulse; re-runs the clear sequence.
- o_ready  output  1  high when requests are being serviced.
- o_rd_count  output  32  saturating count of serviced reads.
- o_wr_count  output  32  saturating count of serviced writes.
- o_parity_err  output  1  sticky parity error flag.

## Operation
- Word index = i_addr[$clog2(DEPTH)+1:2].
- i_addr[1:0] and all bits between the index and bit ADDR_WIDTH-1 are ignored. Addresses therefore alias modulo DEPTH words.
- States: SP_CLEAR, SP_READY.
- Reset state:
  - SP_CLEAR with clear_ptr = 0.
  - o_rdata = 0, o_ready = 0, both counters = 0, o_parity_err = 0.
- SP_CLEAR behaviour:
  - Each cycle writes 0 to mem[clear_ptr], then increments clear_ptr.
  - After the write to DEPTH-1, moves to SP_READY and clear_ptr returns to 0.
  - i_req is ignored: no memory access, no counter change, o_rdata holds.
  - i_clear_req is ignored.
- SP_READY behaviour:
  - Write (i_req=1, bit ADDR_WIDTH-1 = 1): mem[idx] <= i_wdata; o_wr_count increments; o_rdata unchanged.
  - Read (i_req=1, bit ADDR_WIDTH-1 = 0): o_rdata <= mem[idx] on the next edge; o_rdata then holds until the next read; o_rd_count increments.
  - i_clear_req=1: moves to SP_CLEAR on the next edge. If i_req is also high in that cycle, the request is serviced first.
- At most one request per cycle, so there is no same-cycle read/write conflict.
- A read issued the cycle after a write to the same index returns the new data.
- Counters saturate at 0xFFFF_FFFF. Only rst clears them; i_clear_req does not.
- rst asserted mid-clear restarts the clear at index 0.

## Timing
- Read latency is 1 cycle. o_rdata is valid on the edge after the request cycle. Masters sample the rdata return path one cycle after issuing a read.
- Write completes on the edge ending the request cycle.
- Clear duration is exactly DEPTH cycles:
  - o_ready rises on the DEPTH-th rising edge after rst deasserts.
  - o_ready falls on the edge that samples i_clear_req.
- o_ready is a registered decode of state.
- Counters update on the same edge as the access.

## Configuration
- SCRATCHPAD_PARITY_EN defined:
  - Storage is DATA_WIDTH+1 bits; even parity of the data is stored on every write, including clear writes.
  - On each serviced read, parity is recomputed. A mismatch sets o_parity_err on the same edge that updates o_rdata.
  - The flag is sticky and is cleared only by rst or by entering SP_CLEAR.
- SCRATCHPAD_PARITY_EN undefined: storage is DATA_WIDTH bits and o_parity_err is tied to 0. The port list is identical in both builds.

## Structure
- Package scratchpad_pkg:
  - sp_state_e enum {SP_CLEAR, SP_READY}.
  - localparam SP_CNT_WIDTH = 32.
  - function sp_parity(data) returning even parity.
- Sub-module sp_ram: synchronous single-port RAM with one write port, one registered read port and parameterised width/depth. It holds the array so that it can map to block RAM.
- Top level holds the FSM, the clear pointer, the address decode, the counters and the parity check.

## Test plan
All scenarios use DEPTH=16.
- Reset release: o_ready=0 for 16 cycles, then 1. Reading words 0..15 returns 0x0000_0000 each, and o_rd_count ends at 16.
- Write 0xDEADBEEF to 0x8000_0010, then read 0x0000_0010 in the next cycle: o_rdata = 0xDEADBEEF one cycle after the read, o_wr_count=1, o_rd_count=1.
- Aliasing: write 0x1234_5678 to 0x8000_0050, then read 0x0000_0010: returns 0x1234_5678.
- Requests during clear: issue writes to 0x8000_0000 throughout the clear. After o_ready=1, o_wr_count=0 and word 0 reads 0.
- i_clear_req after writes: o_ready=0 on the next edge for 16 cycles; a subsequent read of word 4 returns 0; counters retain their prior values.
- Parity:
  - With SCRATCHPAD_PARITY_EN, force-flip a stored bit of word 3 and read word 3: o_parity_err=1 on the read-data edge; it stays 1 until i_clear_req.
  - Without the macro, o_parity_err stays 0.
